lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl.sv | 163 ++++++++++++++++
 tb/tb_lsu_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-port load/store unit controller.
// Turns byte/halfword/word accesses into word-indexed memory accesses.
// Sub-word stores use a read-modify-write pass, so memory only ever sees
// full-word writes. All outputs come straight from registers.
// The lane logic assumes 32-bit memory words (WL >= 32).
module lsu_ctrl #(
  parameter int WL = 32
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          REQ,
  input  logic          WE,
  input  logic [1:0]    SIZE,
  input  logic          SEXT,
  input  logic [WL-1:0] ADDR,
  input  logic [WL-1:0] WDATA,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERR,
  output logic [WL-1:0] RDATA,
  output logic [WL-1:0] DMA,
  output logic          DMWE,
  output logic [WL-1:0] DMWD,
  input  logic [WL-1:0] DMRD
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RMW   = 3'd2,
    STORE = 3'd3,
    RESP  = 3'd4
  } state_e;

  state_e        state_q;
  logic          busy_q, done_q, err_q, dmwe_q;
  logic [WL-1:0] rdata_q, dma_q, dmwd_q;

  // Request fields captured on the accept edge. The word part of the
  // address lives in dma_q; only the in-word byte offset is kept here.
  logic          we_q, sext_q;
  logic [1:0]    size_q, lo_q;
  logic [WL-1:0] wdata_q;

  logic          misaligned;
  logic [4:0]    bsh, hsh;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic [WL-1:0] bmask, hmask;
  logic [WL-1:0] load_d, merge_d;

  // Alignment check on the live request; decides the IDLE exit.
  always_comb begin
    misaligned = (SIZE == 2'b11) ||
                 ((SIZE == 2'b01) && ADDR[0]) ||
                 ((SIZE == 2'b10) && (ADDR[1:0] != 2'b00));
  end

  // Lane extraction for loads and lane merge for RMW, little-endian.
  always_comb begin
    bsh    = {lo_q, 3'b000};
    hsh    = {lo_q[1], 4'b0000};
    lane_b = 8'(DMRD >> bsh);
    lane_h = 16'(DMRD >> hsh);
    bmask  = WL'(8'hFF) << bsh;
    hmask  = WL'(16'hFFFF) << hsh;

    case (size_q)
      2'b00:   load_d = sext_q ? {{(WL-8){lane_b[7]}}, lane_b}
                               : {{(WL-8){1'b0}}, lane_b};
      2'b01:   load_d = sext_q ? {{(WL-16){lane_h[15]}}, lane_h}
                               : {{(WL-16){1'b0}}, lane_h};
      default: load_d = DMRD;
    endcase

    case (size_q)
      2'b00:   merge_d = (DMRD & ~bmask) | ((wdata_q << bsh) & bmask);
      2'b01:   merge_d = (DMRD & ~hmask) | ((wdata_q << hsh) & hmask);
      default: merge_d = DMRD;
    endcase
  end

  // Controller FSM; status strobes are registered alongside the state so
  // they line up with it and reset drops them immediately.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      dmwe_q  <= 1'b0;
      rdata_q <= '0;
      dma_q   <= '0;
      dmwd_q  <= '0;
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      size_q  <= 2'b00;
      lo_q    <= 2'b00;
      wdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      dmwe_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (REQ) begin
            we_q    <= WE;
            sext_q  <= SEXT;
            size_q  <= SIZE;
            lo_q    <= ADDR[1:0];
            wdata_q <= WDATA;
            dma_q   <= {2'b00, ADDR[WL-1:2]};
            busy_q  <= 1'b1;
            if (misaligned) begin
              state_q <= RESP;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (!WE) begin
              state_q <= LOAD;
            end else if (SIZE == 2'b10) begin
              state_q <= STORE;
              dmwd_q  <= WDATA;
              dmwe_q  <= 1'b1;
            end else begin
              state_q <= RMW;
            end
          end
        end
        LOAD: begin
          if (!we_q) rdata_q <= load_d;
          state_q <= RESP;
          done_q  <= 1'b1;
        end
        RMW: begin
          dmwd_q  <= merge_d;
          state_q <= STORE;
          dmwe_q  <= 1'b1;
        end
        STORE: begin
          state_q <= RESP;
          done_q  <= 1'b1;
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign ERR   = err_q;
  assign DMWE  = dmwe_q;
  assign RDATA = rdata_q;
  assign DMA   = dma_q;
  assign DMWD  = dmwd_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed checks of lsu_ctrl against a 16-word memory model.
module tb_lsu_ctrl;
  logic        CLK = 1'b0;
  logic        RSTn, REQ, WE, SEXT;
  logic [1:0]  SIZE;
  logic [31:0] ADDR, WDATA, DMRD;
  logic        BUSY, DONE, ERR, DMWE;
  logic [31:0] RDATA, DMA, DMWD;

  logic [31:0] mem [0:15];
  int          total = 0, bad = 0;
  int          wcnt = 0;
  logic [31:0] last_wd = '0;

  lsu_ctrl #(.WL(32)) dut (
    .CLK(CLK), .RSTn(RSTn), .REQ(REQ), .WE(WE), .SIZE(SIZE), .SEXT(SEXT),
    .ADDR(ADDR), .WDATA(WDATA), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
    .RDATA(RDATA), .DMA(DMA), .DMWE(DMWE), .DMWD(DMWD), .DMRD(DMRD)
  );

  always #5 CLK = ~CLK;

  assign DMRD = mem[DMA[3:0]];

  // Memory write port; also counts write cycles.
  always @(posedge CLK) begin
    if (DMWE) begin
      mem[DMA[3:0]] <= DMWD;
      wcnt    = wcnt + 1;
      last_wd = DMWD;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  // Present one request for a single cycle, then measure edges to DONE.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat);
    @(negedge CLK);
    REQ = 1'b1; WE = we; SIZE = sz; SEXT = sx; ADDR = a; WDATA = wd;
    @(posedge CLK); #1;
    REQ = 1'b0;
    lat = 1;
    while (!DONE && lat < 10) begin
      @(posedge CLK); #1;
      lat++;
    end
  endtask

  task automatic idle_edge;
    @(posedge CLK); #1;
  endtask

  int lat, w0;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[1] = 32'h8899AABB;
    RSTn = 1'b0; REQ = 1'b0; WE = 1'b0; SIZE = 2'b00; SEXT = 1'b0;
    ADDR = '0; WDATA = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", {31'b0, BUSY}, 32'd0);
    chk("rst_done", {31'b0, DONE}, 32'd0);
    chk("rst_err",  {31'b0, ERR},  32'd0);
    chk("rst_dmwe", {31'b0, DMWE}, 32'd0);
    chk("rst_rdata", RDATA, 32'h0);
    chk("rst_dma",   DMA,   32'h0);
    chk("rst_dmwd",  DMWD,  32'h0);
    RSTn = 1'b1;

    // load byte, sign-extended
    do_req(1'b0, 2'b00, 1'b1, 32'h6, 32'h0, lat);
    chk("lb_lat", lat, 2);
    chk("lb_data", RDATA, 32'hFFFFFF99);
    chk("lb_err", {31'b0, ERR}, 32'd0);
    chk("lb_dma", DMA, 32'h1);
    idle_edge();
    chk("lb_idle", {31'b0, BUSY}, 32'd0);

    do_req(1'b0, 2'b01, 1'b0, 32'h4, 32'h0, lat);
    chk("lh_data", RDATA, 32'h0000AABB);
    idle_edge();
    do_req(1'b0, 2'b00, 1'b0, 32'h7, 32'h0, lat);
    chk("lbu_data", RDATA, 32'h00000088);
    idle_edge();
    do_req(1'b0, 2'b01, 1'b1, 32'h6, 32'h0, lat);
    chk("lhs_data", RDATA, 32'hFFFF8899);
    idle_edge();

    // byte store via RMW
    w0 = wcnt;
    do_req(1'b1, 2'b00, 1'b0, 32'h5, 32'h12, lat);
    chk("sb_lat", lat, 3);
    chk("sb_wcnt", wcnt - w0, 1);
    chk("sb_dmwd", last_wd, 32'h889912BB);
    chk("sb_rdata", RDATA, 32'hFFFF8899);
    idle_edge();
    chk("sb_mem", mem[1], 32'h889912BB);

    // misaligned / illegal requests
    w0 = wcnt;
    do_req(1'b1, 2'b10, 1'b0, 32'h2, 32'hCAFEF00D, lat);
    chk("sw_mis_lat", lat, 1);
    chk("sw_mis_err", {31'b0, ERR}, 32'd1);
    idle_edge();
    do_req(1'b1, 2'b01, 1'b0, 32'h5, 32'h1234, lat);
    chk("sh_mis_err", {31'b0, ERR}, 32'd1);
    idle_edge();
    do_req(1'b0, 2'b11, 1'b0, 32'h4, 32'h0, lat);
    chk("ill_err", {31'b0, ERR}, 32'd1);
    chk("ill_rdata", RDATA, 32'hFFFF8899);
    idle_edge();
    chk("mis_wcnt", wcnt - w0, 0);
    chk("mis_mem", mem[1], 32'h889912BB);

    // word store
    w0 = wcnt;
    do_req(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEADBEEF, lat);
    chk("sw_lat", lat, 2);
    chk("sw_err", {31'b0, ERR}, 32'd0);
    chk("sw_wcnt", wcnt - w0, 1);
    idle_edge();
    chk("sw_mem", mem[2], 32'hDEADBEEF);

    // REQ held high through a word load: no queuing, re-accept after DONE
    @(negedge CLK);
    REQ = 1'b1; WE = 1'b0; SIZE = 2'b10; SEXT = 1'b0; ADDR = 32'h8;
    @(posedge CLK); #1;
    lat = 1;
    while (!DONE && lat < 10) begin
      @(posedge CLK); #1;
      lat++;
    end
    chk("hold_lat", lat, 2);
    chk("hold_data", RDATA, 32'hDEADBEEF);
    ADDR = 32'h4;
    @(posedge CLK); #1;
    chk("hold_idle", {31'b0, BUSY}, 32'd0);
    @(posedge CLK); #1;
    chk("hold_reacc", {31'b0, BUSY}, 32'd1);
    chk("hold_dma", DMA, 32'h1);
    REQ = 1'b0;
    lat = 1;
    while (!DONE && lat < 10) begin
      @(posedge CLK); #1;
      lat++;
    end
    chk("hold2_data", RDATA, 32'h889912BB);
    idle_edge();

    // reset during STORE of a halfword store
    w0 = wcnt;
    @(negedge CLK);
    REQ = 1'b1; WE = 1'b1; SIZE = 2'b01; SEXT = 1'b0; ADDR = 32'h4; WDATA = 32'h5555;
    @(posedge CLK); #1;
    REQ = 1'b0;
    @(posedge CLK); #1;
    chk("rs_dmwe_on", {31'b0, DMWE}, 32'd1);
    chk("rs_dmwd", DMWD, 32'h88995555);
    RSTn = 1'b0;
    #1;
    chk("rs_dmwe_off", {31'b0, DMWE}, 32'd0);
    chk("rs_busy", {31'b0, BUSY}, 32'd0);
    @(posedge CLK); #1;
    RSTn = 1'b1;
    chk("rs_wcnt", wcnt - w0, 0);
    chk("rs_mem", mem[1], 32'h889912BB);
    chk("rs_rdata", RDATA, 32'h0);

    // request in the first cycle after reset release
    do_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, lat);
    chk("post_lat", lat, 2);
    chk("post_data", RDATA, 32'h889912BB);
    idle_edge();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
